// File: rtl/div_8.sv
// Sequential 8-bit restoring divider with a start/busy/done handshake and held results.
// Defining DIV_8_SIGNED_EN adds the sgn input for two's-complement division.
module div_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef DIV_8_SIGNED_EN
    input  logic       sgn,
`endif
    input  logic [7:0] X,
    input  logic [7:0] Y,
    output logic       busy,
    output logic       done,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       ZF,
    output logic       DZ,
    output logic       OF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [8:0] p;
    logic [7:0] d;
    logic [7:0] dvs;
    logic [2:0] count;
    logic       neg_q, neg_r, ovf;

    logic       sgn_i;
    logic       accept;
    logic [7:0] x_mag, y_mag;
    logic [8:0] p_sh;
    logic [9:0] t;
    logic       qbit;
    logic [8:0] p_n;
    logic [7:0] q_mag, q_fin, r_fin;
    logic       unused_bits;

`ifdef DIV_8_SIGNED_EN
    assign sgn_i = sgn;
`else
    assign sgn_i = 1'b0;
`endif

    assign accept = start && !busy;
    assign x_mag  = (sgn_i && X[7]) ? (~X + 8'd1) : X;
    assign y_mag  = (sgn_i && Y[7]) ? (~Y + 8'd1) : Y;

    // One trial subtraction per cycle in the ALU's X + ~Y + 1 form; carry-out means no borrow.
    assign p_sh  = {p[7:0], d[7]};
    assign t     = {1'b0, p_sh} + {1'b0, ~{1'b0, dvs}} + 10'd1;
    assign qbit  = t[9];
    assign p_n   = qbit ? t[8:0] : p_sh;
    assign q_mag = {d[6:0], qbit};
    assign q_fin = neg_q ? (~q_mag + 8'd1) : q_mag;
    assign r_fin = neg_r ? (~p_n[7:0] + 8'd1) : p_n[7:0];

    // The restored remainder is always below the divisor, so its top bit never feeds back.
    assign unused_bits = p[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_CALC: begin
                busy = 1'b1;
                if (count == 3'd7) begin
                    state_nxt = S_DONE;
                end
            end
            S_IDLE, S_DONE, S_ZERO: begin
                done      = (state != S_IDLE);
                state_nxt = S_IDLE;
                if (start) begin
                    state_nxt = (Y == 8'h00) ? S_ZERO : S_CALC;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p     <= 9'd0;
            d     <= 8'd0;
            dvs   <= 8'd0;
            count <= 3'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf   <= 1'b0;
            Q     <= 8'h00;
            R     <= 8'h00;
            ZF    <= 1'b0;
            DZ    <= 1'b0;
            OF    <= 1'b0;
        end else if (accept) begin
            p     <= 9'd0;
            d     <= x_mag;
            dvs   <= y_mag;
            count <= 3'd0;
            neg_q <= sgn_i && (X[7] ^ Y[7]);
            neg_r <= sgn_i && X[7];
            ovf   <= sgn_i && (X == 8'h80) && (Y == 8'hFF);
            DZ    <= 1'b0;
            OF    <= 1'b0;
            if (Y == 8'h00) begin
                Q  <= 8'hFF;
                R  <= X;
                ZF <= 1'b0;
                DZ <= 1'b1;
            end
        end else if (state == S_CALC) begin
            p     <= p_n;
            d     <= q_mag;
            count <= count + 3'd1;
            if (count == 3'd7) begin
                Q  <= q_fin;
                R  <= r_fin;
                ZF <= (q_fin == 8'h00);
                OF <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_div_8.sv
// Self-checking bench for div_8: directed scenarios plus randomized operations against an arithmetic model.
// Builds with or without DIV_8_SIGNED_EN.
module tb_div_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sgn = 1'b0;
    logic [7:0] X = 8'h00;
    logic [7:0] Y = 8'h00;
    logic       busy, done, ZF, DZ, OF;
    logic [7:0] Q, R;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    div_8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef DIV_8_SIGNED_EN
        .sgn   (sgn),
`endif
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .ZF    (ZF),
        .DZ    (DZ),
        .OF    (OF)
    );

    // Expected {Q, R, ZF, DZ, OF} from plain integer division.
    function automatic logic [18:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi, yi, qi, ri;
        logic [7:0] q, r;
        if (y == 8'h00) return {8'hFF, x, 1'b0, 1'b1, 1'b0};
        if (s) begin
            xi = $signed(x);
            yi = $signed(y);
            if (xi == -128 && yi == -1) return {8'h80, 8'h00, 1'b0, 1'b0, 1'b1};
            qi = xi / yi;
            ri = xi % yi;
            q  = qi[7:0];
            r  = ri[7:0];
            return {q, r, (q == 8'h00), 1'b0, 1'b0};
        end
        xi = x;
        yi = y;
        qi = xi / yi;
        ri = xi % yi;
        q  = qi[7:0];
        r  = ri[7:0];
        return {q, r, (q == 8'h00), 1'b0, 1'b0};
    endfunction

    // Called at a falling edge; issues one request and returns at the falling edge where done is seen.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          output int lat, output logic [18:0] obs);
        start = 1'b1;
        X     = x;
        Y     = y;
        sgn   = s;
        lat   = 0;
        obs   = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            X     = 8'($urandom);
            Y     = 8'($urandom);
            if (done) begin
                lat = i;
                obs = {Q, R, ZF, DZ, OF};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, Q, R, ZF, DZ, OF} !== 21'd0)
            $display("FAIL reset_state: got %h expected %h", {busy, done, Q, R, ZF, DZ, OF}, 21'd0);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        logic [18:0] obs;
        run_op(8'd100, 8'd7, 1'b0, lat, obs);
        total++;
        if (lat !== 9) $display("FAIL basic_latency: got %0d expected %0d", lat, 9);
        else pass_cnt++;
        total++;
        if (obs !== {8'd14, 8'd2, 1'b0, 1'b0, 1'b0})
            $display("FAIL basic_result: got %h expected %h", obs, {8'd14, 8'd2, 3'b000});
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) $display("FAIL basic_done_single: got %b expected %b", {done, busy}, 2'b00);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [18:0] obs;
        run_op(8'd255, 8'd1, 1'b0, lat, obs);
        total++;
        if (obs !== {8'd255, 8'd0, 3'b000}) $display("FAIL b2b_first: got %h expected %h", obs, {8'd255, 8'd0, 3'b000});
        else pass_cnt++;
        run_op(8'd0, 8'd3, 1'b0, lat, obs);
        total++;
        if (lat !== 9) $display("FAIL b2b_accept_latency: got %0d expected %0d", lat, 9);
        else pass_cnt++;
        total++;
        if (obs !== {8'd0, 8'd0, 3'b100}) $display("FAIL b2b_second: got %h expected %h", obs, {8'd0, 8'd0, 3'b100});
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat;
        logic [18:0] obs;
        run_op(8'd5, 8'd0, 1'b0, lat, obs);
        total++;
        if (lat !== 1) $display("FAIL dz_latency: got %0d expected %0d", lat, 1);
        else pass_cnt++;
        total++;
        if (obs !== {8'hFF, 8'd5, 3'b010}) $display("FAIL dz_result: got %h expected %h", obs, {8'hFF, 8'd5, 3'b010});
        else pass_cnt++;
        @(negedge clk);
        run_op(8'd10, 8'd3, 1'b0, lat, obs);
        total++;
        if (obs !== {8'd3, 8'd1, 3'b000}) $display("FAIL dz_cleared: got %h expected %h", obs, {8'd3, 8'd1, 3'b000});
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ignore_and_abort();
        int lat;
        bit seen;
        logic [18:0] obs;
        start = 1'b1; X = 8'd200; Y = 8'd9; sgn = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; X = 8'd1; Y = 8'd1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        obs = 'x;
        for (int i = 5; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                obs = {Q, R, ZF, DZ, OF};
                break;
            end
        end
        total++;
        if (lat !== 9) $display("FAIL ignore_latency: got %0d expected %0d", lat, 9);
        else pass_cnt++;
        total++;
        if (obs !== {8'd22, 8'd2, 3'b000}) $display("FAIL ignore_result: got %h expected %h", obs, {8'd22, 8'd2, 3'b000});
        else pass_cnt++;
        start = 1'b1; X = 8'd50; Y = 8'd3;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        total++;
        if ({busy, done, Q, R, ZF, DZ, OF} !== 21'd0)
            $display("FAIL abort_state: got %h expected %h", {busy, done, Q, R, ZF, DZ, OF}, 21'd0);
        else pass_cnt++;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL abort_no_done: got %b expected %b", seen, 1'b0);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        int lat;
        logic [18:0] obs;
        run_op(8'd7, 8'd255, 1'b0, lat, obs);
        total++;
        if (obs !== {8'd0, 8'd7, 3'b100}) $display("FAIL edge_7_255: got %h expected %h", obs, {8'd0, 8'd7, 3'b100});
        else pass_cnt++;
        run_op(8'd255, 8'd255, 1'b0, lat, obs);
        total++;
        if (obs !== {8'd1, 8'd0, 3'b000}) $display("FAIL edge_255_255: got %h expected %h", obs, {8'd1, 8'd0, 3'b000});
        else pass_cnt++;
        @(negedge clk);
    endtask

`ifdef DIV_8_SIGNED_EN
    task automatic test_signed();
        int lat;
        logic [18:0] obs;
        run_op(8'hF9, 8'h02, 1'b1, lat, obs);
        total++;
        if (obs !== {8'hFD, 8'hFF, 3'b000}) $display("FAIL signed_m7_2: got %h expected %h", obs, {8'hFD, 8'hFF, 3'b000});
        else pass_cnt++;
        total++;
        if (lat !== 9) $display("FAIL signed_latency: got %0d expected %0d", lat, 9);
        else pass_cnt++;
        run_op(8'h80, 8'hFF, 1'b1, lat, obs);
        total++;
        if (obs !== {8'h80, 8'h00, 3'b001}) $display("FAIL signed_overflow: got %h expected %h", obs, {8'h80, 8'h00, 3'b001});
        else pass_cnt++;
        run_op(8'h80, 8'hFF, 1'b0, lat, obs);
        total++;
        if (obs !== {8'h00, 8'h80, 3'b100}) $display("FAIL unsigned_80_ff: got %h expected %h", obs, {8'h00, 8'h80, 3'b100});
        else pass_cnt++;
        run_op(8'h90, 8'h00, 1'b1, lat, obs);
        total++;
        if (obs !== {8'hFF, 8'h90, 3'b010}) $display("FAIL signed_dz: got %h expected %h", obs, {8'hFF, 8'h90, 3'b010});
        else pass_cnt++;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int lat;
        logic [18:0] obs, exp;
        logic [7:0] x, y;
        logic s;
        for (int n = 0; n < 40; n++) begin
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
`ifdef DIV_8_SIGNED_EN
            s = 1'($urandom);
            if (n == 5) begin x = 8'h80; y = 8'hFF; end
`else
            s = 1'b0;
`endif
            exp = model(x, y, s);
            run_op(x, y, s, lat, obs);
            total++;
            if (lat !== ((y == 8'h00) ? 1 : 9))
                $display("FAIL rand_latency: x=%h y=%h s=%b got %0d expected %0d", x, y, s, lat, (y == 8'h00) ? 1 : 9);
            else pass_cnt++;
            total++;
            if (obs !== exp) $display("FAIL rand_result: x=%h y=%h s=%b got %h expected %h", x, y, s, obs, exp);
            else pass_cnt++;
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                total++;
                if ({done, Q, R, ZF, DZ, OF} !== {1'b0, exp})
                    $display("FAIL rand_hold: got %h expected %h", {done, Q, R, ZF, DZ, OF}, {1'b0, exp});
                else pass_cnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_and_abort();
        test_edges();
`ifdef DIV_8_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/div_8.md
# div_8

Sequential 8-bit restoring divider, the inverse-operation companion to the 8-bit adder/ALU datapath. It reuses the ALU's subtract form (X + ~Y + 1, carry-out = no borrow) for one trial subtraction per cycle. A start/busy/done handshake connects it to the same controller that drives the ALU. Quotient, remainder and ZF/OF-style flags are registered and held until the next operation.

## Interface
- No parameters; width fixed at 8.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `X`  in  8  dividend; sampled on the accepting edge
- `Y`  in  8  divisor; sampled on the accepting edge
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse: `Q`, `R` and flags are valid
- `Q`  out  8  quotient (registered, held)
- `R`  out  8  remainder (registered, held)
- `ZF`  out  1  Q == 8'h00 (valid with `done`, held)
- `DZ`  out  1  divide-by-zero flag (held)
- `OF`  out  1  overflow; only ever set in signed mode, 0 otherwise

## Operation
- Reset values: `busy`=0, `done`=0, `Q`=8'h00, `R`=8'h00, `ZF`=0, `DZ`=0, `OF`=0. The FSM goes to IDLE.
- States:
  - IDLE: `start`=1 latches X/Y, clears `DZ`/`OF`. Goes to ZERO if Y==0, else to CALC with count=0.
  - CALC: 8 iterations.
  - DONE: one cycle, `done`=1, then back to IDLE.
  - ZERO: one cycle, `done`=1, then back to IDLE.
- CALC iteration, MSB first:
  - 9-bit partial remainder P and shifted dividend D.
  - Shift: P' = {P[7:0], D[7]}, D <<= 1.
  - Trial: T = {1'b0,P'} + {1'b0,~{1'b0,Y}} + 1, taken as a 10-bit sum.
  - Carry-out 1 (no borrow): P = T[8:0] and the quotient bit is 1. Otherwise P = P' and the bit is 0.
  - count wraps 7→0 on leaving CALC.
- Result write: `Q`, `R` (= P[7:0]), `ZF` are written on the edge that enters DONE.
- Divide by zero: `Q`=8'hFF, `R`=X, `DZ`=1, `ZF`=0.
- `start` while `busy`=1 is ignored. No queuing and no error flag.
- Reset mid-operation aborts with no `done` pulse and restores all reset values.
- Outputs are stable from `done` until the next accepting edge.

## Timing
- Accepting edge E, with `start`=1, `busy`=0: `busy`=1 from E.
- Normal operation: CALC runs over edges E+1..E+8 and results are registered at E+8. `done`=1 during the cycle after E+8, and `busy` drops at the same edge `done` rises.
- Divide by zero: `done`=1 during the cycle after E. Latency 1.
- `start` asserted in the same cycle `done`=1 is accepted, since `busy`=0 there. That gives back-to-back issue every 9 cycles.
- `rst` and `start` high together: `rst` wins.
- `done` is never high for more than one consecutive cycle.

## Configuration
- `DIV_8_SIGNED_EN` defined: adds input `sgn` (1 bit, sampled with X/Y).
  - With `sgn`=1, operands are two's complement and the unsigned core divides |X| by |Y|.
  - Q is negated if X[7]^Y[7]. R takes the sign of X.
  - -128/-1 sets `OF`=1 with `Q`=8'h80, `R`=8'h00.
  - Divide by zero gives `Q`=8'hFF, `R`=X regardless of sign.
  - Magnitude and negation fold into the existing edges; latency is unchanged.
- Undefined: no `sgn` port, purely unsigned, `OF` tied 0.

## Test plan
- X=100, Y=7, start pulse → `done` exactly 9 cycles after accept edge (cycle after E+8); Q=14, R=2, ZF=0, DZ=0.
- X=255, Y=1 → Q=255, R=0. Then X=0, Y=3 issued in the `done` cycle → accepted; Q=0, R=0, ZF=1.
- X=5, Y=0 → `done` the cycle after accept; Q=8'hFF, R=5, DZ=1. Next valid op clears DZ.
- X=200, Y=9, `start` re-pulsed at E+3 with X=1, Y=1 → ignored; result Q=22, R=2. Then a new op with `rst` at E+4 → no `done`, all outputs 0, `busy`=0.
- Edge values: X=7, Y=255 → Q=0, R=7, ZF=1. X=255, Y=255 → Q=1, R=0.
- `DIV_8_SIGNED_EN`, sgn=1:
  - X=8'hF9 (-7), Y=2 → Q=8'hFD (-3), R=8'hFF (-1).
  - X=8'h80, Y=8'hFF → OF=1, Q=8'h80, R=0.
  - Same operands with sgn=0 → Q=0, R=8'h80.
